// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronizes and glitch-filters A/B/index,
// then turns Gray-code steps and index edges into counter enable/up/load strobes.
module quad_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic a_in,
    input  logic b_in,
    input  logic idx_in,
    input  logic idx_en,
    input  logic err_clr,
    output logic enable,
    output logic up,
    output logic load,
    output logic err,
    output logic ready
);

    localparam int CW     = $clog2(FILT_CYCLES + 1);
    localparam int SETTLE = SYNC_STAGES + FILT_CYCLES + 1;
    localparam int SW     = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] FILT_LAST   = CW'(FILT_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [2:0]    sync_q [SYNC_STAGES];
    logic [2:0]    synced;
    logic [CW-1:0] filt_cnt [3];
    logic [2:0]    filt_q;
    logic [2:0]    prev_q;
    logic [SW-1:0] settle_cnt;
    logic [SW-1:0] settle_next;
    logic          enable_next;
    logic          up_next;
    logic          load_next;
    logic          err_next;
    logic          step;
    logic          dir_up;
    logic          illegal;
    logic          idx_rise;

    // Channel bit order everywhere is {idx, b, a}.
    assign synced   = sync_q[SYNC_STAGES-1];
    assign idx_rise = filt_q[2] & ~prev_q[2];
    assign ready    = (state == TRACK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {idx_in, b_in, a_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // A new level is accepted only after FILT_CYCLES consecutive mismatches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            for (int c = 0; c < 3; c++) begin
                filt_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (synced[c] == filt_q[c]) begin
                    filt_cnt[c] <= '0;
                end else if (filt_cnt[c] == FILT_LAST) begin
                    filt_q[c]   <= synced[c];
                    filt_cnt[c] <= '0;
                end else begin
                    filt_cnt[c] <= filt_cnt[c] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        step    = 1'b0;
        dir_up  = up;
        illegal = 1'b0;
        case ({prev_q[0], prev_q[1], filt_q[0], filt_q[1]})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
                step   = 1'b1;
                dir_up = 1'b1;
            end
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: begin
                step   = 1'b1;
                dir_up = 1'b0;
            end
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: illegal = 1'b1;
            default: ;
        endcase
    end

    // INIT lets the synchronizers and filters settle so a level present at
    // reset release is absorbed into prev instead of decoding as a step.
    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        enable_next = 1'b0;
        load_next   = 1'b0;
        up_next     = up;
        err_next    = err;
        case (state)
            INIT: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = TRACK;
                end else begin
                    settle_next = settle_cnt + SW'(1);
                end
            end
            TRACK: begin
                if (err_clr) begin
                    err_next = 1'b0;
                end
                if (illegal) begin
                    err_next = 1'b1;
                end
                if (step) begin
                    enable_next = 1'b1;
                    up_next     = dir_up;
                end
                if (idx_en && idx_rise) begin
                    enable_next = 1'b1;
                    load_next   = 1'b1;
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= INIT;
            settle_cnt <= '0;
            prev_q     <= '0;
            enable     <= 1'b0;
            up         <= 1'b1;
            load       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_next;
            prev_q     <= filt_q;
            enable     <= enable_next;
            up         <= up_next;
            load       <= load_next;
            err        <= err_next;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Randomized and directed bench for quad_decoder against a window-based
// behavioural model of the synchronizer, filter and Gray-code decode.
module tb_quad_decoder;

    localparam int SYNC_STAGES = 2;
    localparam int FILT_CYCLES = 4;
    localparam int SETTLE      = SYNC_STAGES + FILT_CYCLES + 1;

    logic clk = 1'b0;
    logic reset_n;
    logic a_in;
    logic b_in;
    logic idx_in;
    logic idx_en;
    logic err_clr;
    logic enable;
    logic up;
    logic load;
    logic err;
    logic ready;

    int vectors     = 0;
    int miscompares = 0;
    int pulses_seen = 0;
    int clr_hits    = 0;

    int         edge_cnt;
    logic [2:0] raw_hist [$];
    logic [2:0] filt_cur;
    logic [2:0] filt_old;
    logic       m_en;
    logic       m_up;
    logic       m_load;
    logic       m_err;
    logic       m_ready;

    quad_decoder #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYCLES(FILT_CYCLES)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .a_in   (a_in),
        .b_in   (b_in),
        .idx_in (idx_in),
        .idx_en (idx_en),
        .err_clr(err_clr),
        .enable (enable),
        .up     (up),
        .load   (load),
        .err    (err),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    function automatic int posOf(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [2:0] syncedAt(input int j);
        if (j - SYNC_STAGES < 0) return 3'b000;
        return raw_hist[j - SYNC_STAGES];
    endfunction

    function automatic int stepDelta();
        return (posOf({filt_cur[0], filt_cur[1]}) - posOf({filt_old[0], filt_old[1]}) + 4) % 4;
    endfunction

    function automatic bit illegalNext();
        return (edge_cnt >= SETTLE) && (stepDelta() == 2);
    endfunction

    task automatic modelReset();
        edge_cnt = 0;
        raw_hist.delete();
        filt_cur = 3'b000;
        filt_old = 3'b000;
        m_en     = 1'b0;
        m_up     = 1'b1;
        m_load   = 1'b0;
        m_err    = 1'b0;
        m_ready  = 1'b0;
    endtask

    // Outputs after edge k come from the filtered levels after edges k-1 and k-2;
    // a filtered level flips once the last FILT_CYCLES synced samples all disagree with it.
    task automatic modelEdge(input logic [2:0] raw, input logic en, input logic clr);
        logic [2:0] f_new;
        logic [2:0] s;
        bit         all_diff;
        int         d;
        edge_cnt++;
        raw_hist.push_back(raw);
        m_en   = 1'b0;
        m_load = 1'b0;
        if (edge_cnt - 1 >= SETTLE) begin
            d = stepDelta();
            if (clr) m_err = 1'b0;
            if (d == 1) begin
                m_en = 1'b1;
                m_up = 1'b1;
            end else if (d == 3) begin
                m_en = 1'b1;
                m_up = 1'b0;
            end else if (d == 2) begin
                m_err = 1'b1;
            end
            if (en && filt_cur[2] && !filt_old[2]) begin
                m_en   = 1'b1;
                m_load = 1'b1;
            end
        end
        m_ready = (edge_cnt >= SETTLE);
        for (int c = 0; c < 3; c++) begin
            all_diff = 1'b1;
            for (int j = edge_cnt - FILT_CYCLES; j < edge_cnt; j++) begin
                s = syncedAt(j);
                if (s[c] == filt_cur[c]) all_diff = 1'b0;
            end
            f_new[c] = all_diff ? ~filt_cur[c] : filt_cur[c];
        end
        filt_old = filt_cur;
        filt_cur = f_new;
    endtask

    task automatic checkAll();
        checkOutput("enable", 32'(enable), 32'(m_en));
        checkOutput("up",     32'(up),     32'(m_up));
        checkOutput("load",   32'(load),   32'(m_load));
        checkOutput("err",    32'(err),    32'(m_err));
        checkOutput("ready",  32'(ready),  32'(m_ready));
        if (enable === 1'b1) pulses_seen++;
    endtask

    // Entered and left at a falling clock edge.
    task automatic applyStimulus(input logic a, input logic b, input logic idx,
                                 input logic en, input logic clr);
        a_in    = a;
        b_in    = b;
        idx_in  = idx;
        idx_en  = en;
        err_clr = clr;
        @(posedge clk);
        modelEdge({idx, b, a}, en, clr);
        @(negedge clk);
        checkAll();
    endtask

    // clr_mode: 0 never, 1 only on the edge that detects an illegal step, 2 random
    task automatic holdLevel(input logic a, input logic b, input logic idx, input logic en,
                             input int cycles, input int clr_mode);
        logic clr;
        for (int n = 0; n < cycles; n++) begin
            clr = 1'b0;
            if (clr_mode == 1 && illegalNext()) begin
                clr = 1'b1;
                clr_hits++;
            end else if (clr_mode == 2) begin
                clr = ($urandom_range(0, 7) == 0);
            end
            applyStimulus(a, b, idx, en, clr);
        end
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        modelReset();
        #1;
        checkAll();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        a_in    = 1'b0;
        b_in    = 1'b0;
        idx_in  = 1'b0;
        idx_en  = 1'b0;
        err_clr = 1'b0;
        modelReset();
        @(negedge clk);
        doReset();

        holdLevel(0, 0, 0, 0, 10, 0);
        checkOutput("ready_after_settle", 32'(ready), 32'd1);

        pulses_seen = 0;
        holdLevel(1, 0, 0, 0, 10, 0);
        holdLevel(1, 1, 0, 0, 10, 0);
        holdLevel(0, 1, 0, 0, 10, 0);
        holdLevel(0, 0, 0, 0, 10, 0);
        checkOutput("up_walk_pulses", 32'(pulses_seen), 32'd4);

        pulses_seen = 0;
        holdLevel(1, 0, 1, 1, 10, 0);
        holdLevel(1, 0, 0, 1, 10, 0);
        holdLevel(0, 0, 1, 0, 10, 0);
        holdLevel(0, 0, 0, 0, 10, 0);
        checkOutput("index_pulses", 32'(pulses_seen), 32'd2);

        pulses_seen = 0;
        holdLevel(0, 1, 0, 0, 10, 0);
        holdLevel(1, 1, 0, 0, 10, 0);
        holdLevel(1, 0, 0, 0, 10, 0);
        holdLevel(0, 0, 0, 0, 10, 0);
        checkOutput("down_walk_pulses", 32'(pulses_seen), 32'd4);

        pulses_seen = 0;
        holdLevel(1, 0, 0, 0, 3, 0);
        holdLevel(0, 0, 0, 0, 10, 0);
        checkOutput("short_glitch_pulses", 32'(pulses_seen), 32'd0);
        holdLevel(1, 0, 0, 0, 4, 0);
        holdLevel(0, 0, 0, 0, 10, 0);
        checkOutput("min_pulse_pulses", 32'(pulses_seen), 32'd2);

        pulses_seen = 0;
        holdLevel(1, 1, 0, 0, 10, 0);
        applyStimulus(1, 1, 0, 0, 1);
        holdLevel(1, 1, 0, 0, 3, 0);
        holdLevel(0, 0, 0, 0, 10, 1);
        checkOutput("illegal_pulses", 32'(pulses_seen), 32'd0);
        checkOutput("clr_coincide_hit", 32'(clr_hits), 32'd1);
        checkOutput("err_after_coincide", 32'(err), 32'd1);

        holdLevel(1, 1, 0, 0, 3, 0);
        doReset();
        pulses_seen = 0;
        holdLevel(1, 1, 0, 0, 12, 0);
        checkOutput("held_level_pulses", 32'(pulses_seen), 32'd0);

        for (int seg = 0; seg < 200; seg++) begin
            holdLevel(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(1, 12)), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
